dcache_qspi: RTL and testbench



---
 rtl/mem_pkg.sv | 35 +++
 rtl/dcache_qspi_if.sv | 30 +++
 rtl/dcache_qspi.sv | 148 ++++++++++++++
 tb/tb_dcache_qspi.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-cache QSPI memory controller: FSM states,
// transfer lengths and default PSRAM opcodes.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        DONE
    } state_t;

    localparam int NIBBLES_CMD  = 2;
    localparam int NIBBLES_ADDR = 6;
    localparam int NIBBLES_LINE = 8;

    localparam logic [7:0] DEF_READ_CMD  = 8'hEB;
    localparam logic [7:0] DEF_WRITE_CMD = 8'h38;

    // Nibble idx of the 24-bit address, idx 0 being the most significant.
    function automatic logic [3:0] addr_nibble(input logic [23:0] addr, input logic [2:0] idx);
        logic [3:0] nib;
        case (idx)
            3'd0:    nib = addr[23:20];
            3'd1:    nib = addr[19:16];
            3'd2:    nib = addr[15:12];
            3'd3:    nib = addr[11:8];
            3'd4:    nib = addr[7:4];
            default: nib = addr[3:0];
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/dcache_qspi_if.sv
// Bundle of cache-side miss/strobe signals and the quad-SPI pins of dcache_qspi.
interface dcache_qspi_if #(
    parameter int PA = 22
);
    logic          active;
    logic          pull;
    logic          push;
    logic [PA-3:0] tag;
    logic [3:0]    dwrite;
    logic [3:0]    dread;
    logic          wstrobe_d;
    logic          rstrobe_d;
    logic          busy;
    logic          spi_cs_n;
    logic          spi_sck;
    logic          spi_oe;
    logic [3:0]    spi_dout;
    logic [3:0]    spi_din;

    // master: cache plus memory device; slave: the controller itself
    modport master (
        output active, pull, push, tag, dwrite, spi_din,
        input  dread, wstrobe_d, rstrobe_d, busy, spi_cs_n, spi_sck, spi_oe, spi_dout
    );

    modport slave (
        input  active, pull, push, tag, dwrite, spi_din,
        output dread, wstrobe_d, rstrobe_d, busy, spi_cs_n, spi_sck, spi_oe, spi_dout
    );
endinterface

// File: rtl/dcache_qspi.sv
// Data-cache line fill/writeback engine: moves one 4-byte line as 8 nibbles
// over a QPI-mode PSRAM bus with SCK = clk/2.
module dcache_qspi
    import mem_pkg::*;
#(
    parameter int         PA         = 22,
    parameter logic [7:0] READ_CMD   = DEF_READ_CMD,
    parameter logic [7:0] WRITE_CMD  = DEF_WRITE_CMD,
    parameter int         READ_DUMMY = 6,
    parameter int         CS_HIGH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    dcache_qspi_if.slave bus
);

    state_t        r_state, w_state_nx;
    logic [3:0]    r_cnt, w_cnt_nx;
    logic          r_phase, w_phase_nx;
    logic          r_op_wr, w_op_wr_nx;
    logic [PA-3:0] r_tag, w_tag_nx;
    logic [3:0]    r_dread, w_dread_nx;
    logic          r_wstrobe, w_wstrobe_nx;
    logic [3:0]    r_wdata, w_wdata_nx;

    logic [23:0]   w_addr;
    logic [7:0]    w_cmd;
    logic [3:0]    w_limit;
    logic          w_last;
    logic          w_xfer;

    assign w_addr = 24'({r_tag, 2'b00});
    assign w_cmd  = r_op_wr ? WRITE_CMD : READ_CMD;

    always_comb begin
        w_limit = 4'd1;
        case (r_state)
            CMD:     w_limit = 4'(NIBBLES_CMD);
            ADDR:    w_limit = 4'(NIBBLES_ADDR);
            DUMMY:   w_limit = 4'(READ_DUMMY);
            DATA:    w_limit = 4'(NIBBLES_LINE);
            DONE:    w_limit = 4'(CS_HIGH);
            default: w_limit = 4'd1;
        endcase
    end

    assign w_last = (r_cnt == w_limit - 4'd1);

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_phase_nx   = r_phase;
        w_op_wr_nx   = r_op_wr;
        w_tag_nx     = r_tag;
        w_dread_nx   = r_dread;
        w_wstrobe_nx = 1'b0;
        w_wdata_nx   = r_wdata;
        case (r_state)
            IDLE: begin
                if (bus.active && (bus.push || bus.pull)) begin
                    w_state_nx = CMD;
                    w_cnt_nx   = 4'd0;
                    w_phase_nx = 1'b0;
                    w_op_wr_nx = bus.push;
                    w_tag_nx   = bus.tag;
                end
            end
            CMD, ADDR, DUMMY, DATA: begin
                w_phase_nx = ~r_phase;
                // Write data is taken at the end of phase 0, read data at the end of phase 1
                if (r_state == DATA && r_op_wr && !r_phase)
                    w_wdata_nx = bus.dwrite;
                if (r_state == DATA && !r_op_wr && r_phase) begin
                    w_dread_nx   = bus.spi_din;
                    w_wstrobe_nx = 1'b1;
                end
                if (r_phase) begin
                    if (w_last) begin
                        w_cnt_nx = 4'd0;
                        case (r_state)
                            CMD:     w_state_nx = ADDR;
                            ADDR:    w_state_nx = r_op_wr ? DATA : DUMMY;
                            DUMMY:   w_state_nx = DATA;
                            default: w_state_nx = DONE;
                        endcase
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end
            end
            DONE: begin
                // CS-high recovery; requests are deliberately ignored here
                if (w_last) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = 4'd0;
                end else begin
                    w_cnt_nx = r_cnt + 4'd1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_phase   <= 1'b0;
            r_op_wr   <= 1'b0;
            r_dread   <= 4'd0;
            r_wstrobe <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_phase   <= w_phase_nx;
            r_op_wr   <= w_op_wr_nx;
            r_dread   <= w_dread_nx;
            r_wstrobe <= w_wstrobe_nx;
        end
    end

    always_ff @(posedge clk) begin
        r_tag   <= w_tag_nx;
        r_wdata <= w_wdata_nx;
    end

    assign w_xfer = (r_state == CMD) || (r_state == ADDR) || (r_state == DUMMY) || (r_state == DATA);

    assign bus.spi_cs_n  = ~w_xfer;
    assign bus.spi_sck   = w_xfer & r_phase;
    assign bus.spi_oe    = (r_state == CMD) || (r_state == ADDR) || (r_state == DATA && r_op_wr);
    assign bus.rstrobe_d = (r_state == DATA) && r_op_wr && !r_phase;
    assign bus.wstrobe_d = r_wstrobe;
    assign bus.dread     = r_dread;
    assign bus.busy      = (r_state != IDLE);

    // dwrite goes straight to the pins in phase 0 and is held from r_wdata across the SCK high phase
    always_comb begin
        bus.spi_dout = 4'd0;
        case (r_state)
            CMD:     bus.spi_dout = (r_cnt == 4'd0) ? w_cmd[7:4] : w_cmd[3:0];
            ADDR:    bus.spi_dout = addr_nibble(w_addr, r_cnt[2:0]);
            DATA:    if (r_op_wr) bus.spi_dout = r_phase ? r_wdata : bus.dwrite;
            default: bus.spi_dout = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_dcache_qspi.sv
// Scoreboard bench for dcache_qspi: directed fill, writeback, push-then-pull,
// held request, gating and mid-transaction reset.
module tb_dcache_qspi;

    typedef struct packed {
        logic       oe;
        logic [3:0] d;
        logic       chk;
    } spi_exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_qspi_if #(.PA(22)) bus ();

    dcache_qspi #(.PA(22)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    spi_exp_t   q_spi[$];
    logic [3:0] q_rd[$];
    int         ws_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ws = 0, n_rs = 0, n_txn = 0;
    int hi_cnt = 0, lo_cnt = 0, done_cnt = 0, last_gap = 0;
    logic prev_cs = 1'b1;
    logic [3:0] rd_line [8];
    logic [3:0] wr_off = 4'd0;

    always @(posedge clk) cyc <= cyc + 1;

    // Cache model: supplies nibble offset+1 and advances on each rstrobe_d
    always @(posedge clk) begin
        if (bus.spi_cs_n) wr_off <= 4'd0;
        else if (bus.rstrobe_d) wr_off <= wr_off + 4'd1;
    end
    assign bus.dwrite = wr_off + 4'd1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_hdr(input logic [7:0] op, input logic [23:0] addr);
        q_spi.push_back({1'b1, op[7:4], 1'b1});
        q_spi.push_back({1'b1, op[3:0], 1'b1});
        for (int i = 0; i < 6; i++) q_spi.push_back({1'b1, addr[23-4*i -: 4], 1'b1});
    endtask

    task automatic push_read(input logic [7:0] op, input logic [23:0] addr, input logic [31:0] line);
        push_hdr(op, addr);
        for (int i = 0; i < 14; i++) q_spi.push_back({1'b0, 4'h0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            rd_line[i] = line[31-4*i -: 4];
            q_rd.push_back(line[31-4*i -: 4]);
        end
    endtask

    task automatic push_write(input logic [7:0] op, input logic [23:0] addr);
        push_hdr(op, addr);
        for (int i = 1; i <= 8; i++) q_spi.push_back({1'b1, 4'(i), 1'b1});
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit && bus.busy; i++) @(negedge clk);
    endtask

    // Memory model: drives read data for nibble slots 14..21 during phase 0
    initial begin
        int idx;
        idx = 0;
        bus.spi_din = 4'h0;
        forever begin
            @(negedge clk);
            if (bus.spi_cs_n) begin
                idx = 0;
                bus.spi_din = 4'h0;
            end else if (!bus.spi_sck) begin
                bus.spi_din = (idx >= 14 && idx < 22) ? rd_line[idx-14] : 4'h0;
            end else begin
                idx++;
            end
        end
    end

    // Monitor: pops the scoreboard on every SCK-high nibble and every strobe
    initial begin
        spi_exp_t e;
        forever begin
            @(negedge clk);
            if (!bus.spi_cs_n) begin
                if (prev_cs) begin
                    n_txn++;
                    last_gap = hi_cnt;
                    hi_cnt = 0;
                    lo_cnt = 0;
                    done_cnt = 0;
                end
                lo_cnt++;
            end else begin
                hi_cnt++;
                if (bus.busy) done_cnt++;
            end
            prev_cs = bus.spi_cs_n;
            if (!reset) begin
                if (!bus.spi_cs_n && bus.spi_sck) begin
                    check("spi_nibble_expected", 32'(q_spi.size() != 0), 32'd1);
                    if (q_spi.size() != 0) begin
                        e = q_spi.pop_front();
                        check("spi_oe", 32'(bus.spi_oe), 32'(e.oe));
                        if (e.chk) check("spi_dout", 32'(bus.spi_dout), 32'(e.d));
                    end
                end
                if (bus.wstrobe_d || bus.rstrobe_d) begin
                    check("strobe_overlap", 32'(bus.wstrobe_d & bus.rstrobe_d), 32'd0);
                    check("strobe_busy", 32'(bus.busy), 32'd1);
                end
                if (bus.wstrobe_d) begin
                    n_ws++;
                    ws_cyc.push_back(cyc);
                    check("dread_expected", 32'(q_rd.size() != 0), 32'd1);
                    if (q_rd.size() != 0) check("dread", 32'(bus.dread), 32'(q_rd.pop_front()));
                end
                if (bus.rstrobe_d) begin
                    n_rs++;
                    check("rstrobe_cs", 32'(bus.spi_cs_n), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running required finished");
        $fatal(1);
    end

    initial begin
        int n0, ws0, rs0, tx0;
        reset = 1'b1;
        bus.active = 1'b0;
        bus.pull = 1'b0;
        bus.push = 1'b0;
        bus.tag = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 32'(bus.spi_cs_n), 32'd1);
        check("rst_sck", 32'(bus.spi_sck), 32'd0);
        check("rst_oe", 32'(bus.spi_oe), 32'd0);
        check("rst_dout", 32'(bus.spi_dout), 32'd0);
        check("rst_dread", 32'(bus.dread), 32'd0);
        check("rst_wstrobe", 32'(bus.wstrobe_d), 32'd0);
        check("rst_rstrobe", 32'(bus.rstrobe_d), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        // Gating: pull without active must not start anything
        bus.pull = 1'b1;
        bus.tag = 20'h12345;
        repeat (20) begin
            @(negedge clk);
            check("gate_cs_n", 32'(bus.spi_cs_n), 32'd1);
        end

        // Read fill
        push_read(8'hEB, 24'h048D14, 32'hA53C0F96);
        ws0 = n_ws; rs0 = n_rs;
        bus.active = 1'b1;
        n0 = cyc;
        @(negedge clk);
        check("rd_cs_fall", 32'(bus.spi_cs_n), 32'd0);
        check("rd_busy_rise", 32'(bus.busy), 32'd1);
        bus.pull = 1'b0;
        wait_idle(200);
        check("rd_busy_fall_cycle", 32'(cyc - n0), 32'd47);
        check("rd_cs_low_cycles", 32'(lo_cnt), 32'd44);
        check("rd_done_cycles", 32'(done_cnt), 32'd2);
        check("rd_spi_left", 32'(q_spi.size()), 32'd0);
        check("rd_dread_left", 32'(q_rd.size()), 32'd0);
        check("rd_wstrobes", 32'(n_ws - ws0), 32'd8);
        check("rd_rstrobes", 32'(n_rs - rs0), 32'd0);
        if (ws_cyc.size() >= ws0 + 1) check("rd_first_wstrobe", 32'(ws_cyc[ws0] - n0), 32'd31);
        for (int i = ws0 + 1; i < ws_cyc.size(); i++)
            check("rd_wstrobe_spacing", 32'(ws_cyc[i] - ws_cyc[i-1]), 32'd2);

        // Writeback with pull also high, then the pending pull fills the same tag
        repeat (3) @(negedge clk);
        push_write(8'h38, 24'h02AF34);
        push_read(8'hEB, 24'h02AF34, 32'h71E2B4D8);
        ws0 = n_ws; rs0 = n_rs; tx0 = n_txn;
        bus.tag = 20'h0ABCD;
        bus.push = 1'b1;
        bus.pull = 1'b1;
        n0 = cyc;
        @(negedge clk);
        check("wr_cs_fall", 32'(bus.spi_cs_n), 32'd0);
        bus.push = 1'b0;
        wait_idle(200);
        check("wr_busy_fall_cycle", 32'(cyc - n0), 32'd35);
        check("wr_rstrobes", 32'(n_rs - rs0), 32'd8);
        check("wr_wstrobes", 32'(n_ws - ws0), 32'd0);
        @(negedge clk);
        check("pp_read_start", 32'(bus.spi_cs_n), 32'd0);
        check("pp_cs_gap", 32'(last_gap), 32'd3);
        // Held request: pull stays high through DONE, dropped once back in IDLE
        wait_idle(200);
        bus.pull = 1'b0;
        check("pp_wstrobes", 32'(n_ws - ws0), 32'd8);
        check("pp_spi_left", 32'(q_spi.size()), 32'd0);
        check("pp_dread_left", 32'(q_rd.size()), 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("held_no_restart", 32'(bus.spi_cs_n), 32'd1);
        end
        check("held_txn_count", 32'(n_txn - tx0), 32'd2);

        // Reset during the 4th read data nibble
        push_read(8'hEB, 24'h000004, 32'h13579BDF);
        bus.tag = 20'h00001;
        bus.pull = 1'b1;
        n0 = cyc;
        @(negedge clk);
        bus.pull = 1'b0;
        for (int i = 0; i < 100 && (cyc - n0) < 35; i++) @(negedge clk);
        check("rst_mid_at_cycle", 32'(cyc - n0), 32'd35);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_cs_n", 32'(bus.spi_cs_n), 32'd1);
        check("rst_mid_wstrobe", 32'(bus.wstrobe_d), 32'd0);
        check("rst_mid_rstrobe", 32'(bus.rstrobe_d), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_oe", 32'(bus.spi_oe), 32'd0);
        check("rst_mid_sck", 32'(bus.spi_sck), 32'd0);
        q_spi.delete();
        q_rd.delete();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("post_rst_idle_cs", 32'(bus.spi_cs_n), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
